// File: rtl/serial_bit_tx_if.sv
// Valid/ready bundle for serial_bit_tx: parallel word in, serial bits out.
// The producer/consumer side uses master; the transmitter uses slave.
interface serial_bit_tx_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_valid;
    logic                  din_ready;
    logic                  sout;
    logic                  sout_valid;
    logic                  sout_last;
    logic                  sout_ready;

    modport master (
        output din,
        output din_valid,
        input  din_ready,
        input  sout,
        input  sout_valid,
        input  sout_last,
        output sout_ready
    );

    modport slave (
        input  din,
        input  din_valid,
        output din_ready,
        output sout,
        output sout_valid,
        output sout_last,
        input  sout_ready
    );
endinterface

// File: rtl/serial_bit_tx.sv
// Parallel-to-serial transmitter, one bit per beat, with a one-word
// holding register so consecutive words stream without idle cycles.
module serial_bit_tx #(
    parameter int DATA_WIDTH = 32,
    parameter bit LSB_FIRST  = 1'b1
) (
    input logic            clk,
    input logic            reset,
    serial_bit_tx_if.slave bus
);
    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] sreg_q, sreg_d;
    logic [DATA_WIDTH-1:0] hold_q, hold_d;
    logic                  hold_vld_q, hold_vld_d;
    logic [CW-1:0]         cnt_q, cnt_d;

    logic                  din_ready;
    logic                  sout_valid;
    logic                  accept;
    logic                  beat;
    logic                  word_end;
    logic [DATA_WIDTH-1:0] shifted;

    // Ready depends only on the hold flag, never on din_valid/sout_ready.
    assign din_ready  = ~hold_vld_q;
    assign sout_valid = (state_q == SHIFT);
    assign accept     = bus.din_valid & din_ready;
    assign beat       = sout_valid & bus.sout_ready;
    assign word_end   = beat & (cnt_q == LAST);
    assign shifted    = LSB_FIRST ? (sreg_q >> 1) : (sreg_q << 1);

    assign bus.din_ready  = din_ready;
    assign bus.sout_valid = sout_valid;
    assign bus.sout_last  = sout_valid & (cnt_q == LAST);
    assign bus.sout       = sout_valid &
                            (LSB_FIRST ? sreg_q[0] : sreg_q[DATA_WIDTH-1]);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            sreg_q     <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            sreg_q     <= sreg_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            cnt_q      <= cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sreg_d     = sreg_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        cnt_d      = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    sreg_d  = bus.din;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (word_end) begin
                    cnt_d = '0;
                    if (hold_vld_q) begin
                        sreg_d     = hold_q;
                        hold_vld_d = 1'b0;
                    end else if (accept) begin
                        sreg_d = bus.din;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    if (beat) begin
                        sreg_d = shifted;
                        cnt_d  = cnt_q + CW'(1);
                    end
                    // A word arriving mid-shift parks in hold.
                    if (accept) begin
                        hold_d     = bus.din;
                        hold_vld_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_bit_tx.sv
// Bench for serial_bit_tx: LSB-first and MSB-first instances share stimulus
// and are checked against a word-queue model of the serial stream.
module tb_serial_bit_tx;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    serial_bit_tx_if #(.DATA_WIDTH(DW)) b0 ();
    serial_bit_tx_if #(.DATA_WIDTH(DW)) b1 ();

    serial_bit_tx #(.DATA_WIDTH(DW), .LSB_FIRST(1'b1)) u_lsb (
        .clk   (clk),
        .reset (reset),
        .bus   (b0)
    );

    serial_bit_tx #(.DATA_WIDTH(DW), .LSB_FIRST(1'b0)) u_msb (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    // Model: words in flight (max 2) and bit position within the head word.
    logic [DW-1:0] wq[$];
    int            hidx = 0;
    logic [DW-1:0] col0 = '0;
    logic [DW-1:0] col1 = '0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] rev(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        for (int i = 0; i < DW; i++) r[i] = w[DW-1-i];
        return r;
    endfunction

    task automatic drive(input bit rst, input bit dv, input logic [DW-1:0] d,
                         input bit sr);
        reset         = rst;
        b0.din        = d;
        b1.din        = d;
        b0.din_valid  = dv;
        b1.din_valid  = dv;
        b0.sout_ready = sr;
        b1.sout_ready = sr;
    endtask

    // Called at a negedge: check outputs, apply inputs, advance the model.
    task automatic step(input bit rst, input bit dv, input logic [DW-1:0] d,
                        input bit sr, output bit acc);
        bit       vld;
        bit       lst;
        bit       e0;
        bit       e1;
        bit       bt;
        vld = (wq.size() > 0);
        lst = vld && (hidx == DW - 1);
        e0  = vld ? wq[0][hidx] : 1'b0;
        e1  = vld ? wq[0][DW-1-hidx] : 1'b0;
        check("rdy0", 32'(b0.din_ready), 32'(wq.size() < 2));
        check("rdy1", 32'(b1.din_ready), 32'(wq.size() < 2));
        check("vld0", 32'(b0.sout_valid), 32'(vld));
        check("vld1", 32'(b1.sout_valid), 32'(vld));
        check("sout0", 32'(b0.sout), 32'(e0));
        check("sout1", 32'(b1.sout), 32'(e1));
        check("last0", 32'(b0.sout_last), 32'(lst));
        check("last1", 32'(b1.sout_last), 32'(lst));
        drive(rst, dv, d, sr);
        acc = 1'b0;
        if (rst) begin
            wq.delete();
            hidx = 0;
            col0 = '0;
            col1 = '0;
        end else begin
            acc = dv && (wq.size() < 2);
            bt  = sr && vld;
            if (bt) begin
                col0 = {col0[DW-2:0], b0.sout};
                col1 = {col1[DW-2:0], b1.sout};
                if (hidx == DW - 1) begin
                    check("word0", 32'(col0), 32'(rev(wq[0])));
                    check("word1", 32'(col1), 32'(wq[0]));
                    void'(wq.pop_front());
                    hidx = 0;
                end else begin
                    hidx++;
                end
            end
            if (acc) wq.push_back(d);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit sr);
        bit a;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, sr, a);
    endtask

    initial begin
        bit a;
        int guard;
        drive(1'b1, 1'b0, '0, 1'b0);
        @(negedge clk);

        // Reset with a word offered: nothing may be taken.
        step(1'b1, 1'b1, 8'hFF, 1'b1, a);
        step(1'b1, 1'b1, 8'hFF, 1'b1, a);
        idle(2, 1'b1);

        // Single word, collector must see 0x2D.
        step(1'b0, 1'b1, 8'hB4, 1'b1, a);
        idle(10, 1'b1);

        // Back-to-back words.
        step(1'b0, 1'b1, 8'h01, 1'b1, a);
        step(1'b0, 1'b1, 8'h80, 1'b1, a);
        idle(18, 1'b1);

        // Stall for 3 cycles after bit 3.
        step(1'b0, 1'b1, 8'hB4, 1'b1, a);
        idle(3, 1'b1);
        idle(3, 1'b0);
        idle(10, 1'b1);

        // Third word offered while full; hold it until taken.
        step(1'b0, 1'b1, 8'hA5, 1'b1, a);
        step(1'b0, 1'b1, 8'h3C, 1'b1, a);
        guard = 0;
        a = 1'b0;
        while (!a && guard < 30) begin
            step(1'b0, 1'b1, 8'hC3, 1'b1, a);
            guard++;
        end
        check("ovf_taken", 32'(a), 32'(1));
        idle(30, 1'b1);

        // Reset mid-word, then a fresh word.
        step(1'b0, 1'b1, 8'h5A, 1'b1, a);
        idle(4, 1'b1);
        step(1'b1, 1'b0, '0, 1'b1, a);
        step(1'b0, 1'b1, 8'h96, 1'b1, a);
        idle(10, 1'b1);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 299) == 0),
                 $urandom_range(0, 1) == 1,
                 DW'($urandom),
                 $urandom_range(0, 3) != 0, a);
        end
        idle(30, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
